if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Owns the PC and issues one fetch request at a time to the instruction memory over a req/ready + valid response handshake.
- Writes the returned instruction and PC+4 into the IF/ID pipeline register feeding decode.
- Honours hazard-unit stalls and branch redirects resolved in MEM, with a 1-entry hold buffer so no response is lost while stalled.

---
 rtl/if_stage.sv | 127 ++++++++++++
 tb/tb_if_stage.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs one-outstanding-request fetches to instruction
// memory and fills the IF/ID register, with a one-entry hold buffer for responses during stalls.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_IM_req,
    output logic [31:0] o_IM_addr,
    input  logic        i_IM_ready,
    input  logic        i_IM_valid,
    input  logic [31:0] i_IM_data,
    input  logic        i_IF_ctrl_Stall,
    input  logic        i_IF_ctrl_PCSrc,
    input  logic [31:0] i_IF_data_BranchTarget,
    output logic [31:0] o_ID_data_instruction,
    output logic        o_ID_valid,
    output logic [31:0] o_EX_data_PCNext
);

    typedef enum logic [1:0] {StReq, StWait, StHold, StDiscard} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pcnext_q, hold_pcnext_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pcnext_q, id_pcnext_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] pc_plus4;
    logic        accept;

    assign pc_plus4  = pc_q + 32'd4;
    assign o_IM_req  = (state_q == StReq) && !rst;
    assign o_IM_addr = pc_q;
    assign accept    = o_IM_req && i_IM_ready;

    assign o_ID_data_instruction = id_instr_q;
    assign o_ID_valid            = id_valid_q;
    assign o_EX_data_PCNext      = id_pcnext_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_instr_d  = hold_instr_q;
        hold_pcnext_d = hold_pcnext_q;
        hold_valid_d  = hold_valid_q;
        id_instr_d    = id_instr_q;
        id_pcnext_d   = id_pcnext_q;
        // Without a load this cycle IF/ID becomes a bubble unless decode is stalled.
        id_valid_d    = i_IF_ctrl_Stall ? id_valid_q : 1'b0;

        if (i_IF_ctrl_PCSrc) begin
            // Redirect beats stall; any response still owed must be dropped in StDiscard.
            pc_d         = i_IF_data_BranchTarget;
            id_valid_d   = 1'b0;
            hold_valid_d = 1'b0;
            case (state_q)
                StReq:     state_d = accept ? StDiscard : StReq;
                StWait:    state_d = i_IM_valid ? StReq : StDiscard;
                StHold:    state_d = StReq;
                StDiscard: state_d = i_IM_valid ? StReq : StDiscard;
                default:   state_d = StReq;
            endcase
        end else begin
            case (state_q)
                StReq: begin
                    if (accept) state_d = StWait;
                end
                StWait: begin
                    if (i_IM_valid) begin
                        if (!i_IF_ctrl_Stall) begin
                            id_instr_d  = i_IM_data;
                            id_pcnext_d = pc_plus4;
                            id_valid_d  = 1'b1;
                            pc_d        = pc_plus4;
                            state_d     = StReq;
                        end else begin
                            hold_instr_d  = i_IM_data;
                            hold_pcnext_d = pc_plus4;
                            hold_valid_d  = 1'b1;
                            state_d       = StHold;
                        end
                    end
                end
                StHold: begin
                    if (!i_IF_ctrl_Stall) begin
                        id_instr_d   = hold_instr_q;
                        id_pcnext_d  = hold_pcnext_q;
                        id_valid_d   = 1'b1;
                        hold_valid_d = 1'b0;
                        pc_d         = pc_plus4;
                        state_d      = StReq;
                    end
                end
                StDiscard: begin
                    if (i_IM_valid) state_d = StReq;
                end
                default: state_d = StReq;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StReq;
            pc_q          <= RESET_PC;
            hold_instr_q  <= 32'd0;
            hold_pcnext_q <= 32'd0;
            hold_valid_q  <= 1'b0;
            id_instr_q    <= 32'd0;
            id_pcnext_q   <= 32'd0;
            id_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_instr_q  <= hold_instr_d;
            hold_pcnext_q <= hold_pcnext_d;
            hold_valid_q  <= hold_valid_d;
            id_instr_q    <= id_instr_d;
            id_pcnext_q   <= id_pcnext_d;
            id_valid_q    <= id_valid_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a cycle table plus hand-written redirect, wrap and reset sequences.
module tb_if_stage;

    typedef struct {
        logic        rst;
        logic        ready;
        logic        valid;
        logic [31:0] data;
        logic        stall;
        logic        pcsrc;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        idv;
        logic [31:0] instr;
        logic [31:0] pcn;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic        im_valid;
    logic [31:0] im_data;
    logic        stall;
    logic        pcsrc;
    logic [31:0] tgt;
    logic [31:0] id_instr;
    logic        id_valid;
    logic [31:0] pc_next;

    int checks;
    int failures;
    logic outstanding;

    vec_t vecs[15];

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .o_IM_req               (im_req),
        .o_IM_addr              (im_addr),
        .i_IM_ready             (im_ready),
        .i_IM_valid             (im_valid),
        .i_IM_data              (im_data),
        .i_IF_ctrl_Stall        (stall),
        .i_IF_ctrl_PCSrc        (pcsrc),
        .i_IF_data_BranchTarget (tgt),
        .o_ID_data_instruction  (id_instr),
        .o_ID_valid             (id_valid),
        .o_EX_data_PCNext       (pc_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, compare outputs, then let the rising edge act.
    task automatic cycle(input string name, input vec_t v);
        @(negedge clk);
        rst      = v.rst;
        im_ready = v.ready;
        im_valid = v.valid;
        im_data  = v.data;
        stall    = v.stall;
        pcsrc    = v.pcsrc;
        tgt      = v.tgt;
        #1;
        chk({name, ".req"},   {31'd0, im_req},   {31'd0, v.req});
        chk({name, ".addr"},  im_addr,           v.addr);
        chk({name, ".idv"},   {31'd0, id_valid}, {31'd0, v.idv});
        chk({name, ".instr"}, id_instr,          v.instr);
        chk({name, ".pcn"},   pc_next,           v.pcn);
        if (v.valid) chk({name, ".owed"}, {31'd0, outstanding}, 32'd1);
        if (v.rst) outstanding = 1'b0;
        else if (im_req && v.ready) outstanding = 1'b1;
        else if (v.valid) outstanding = 1'b0;
    endtask

    function automatic vec_t mk(logic r, logic rdy, logic vld, logic [31:0] d, logic st,
                                logic ps, logic [31:0] t, logic q, logic [31:0] a, logic iv,
                                logic [31:0] ins, logic [31:0] pn);
        vec_t v;
        v = '{rst: r, ready: rdy, valid: vld, data: d, stall: st, pcsrc: ps, tgt: t,
              req: q, addr: a, idv: iv, instr: ins, pcn: pn};
        return v;
    endfunction

    initial begin
        checks      = 0;
        failures    = 0;
        outstanding = 1'b0;
        rst = 1'b1; im_ready = 1'b0; im_valid = 1'b0; im_data = '0;
        stall = 1'b0; pcsrc = 1'b0; tgt = '0;

        //             rst rdy vld data          st ps tgt           req addr          idv instr         pcn
        vecs[0]  = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
        vecs[1]  = mk(0, 1, 1, 32'h2008_0005, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
        vecs[2]  = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h4,        1, 32'h2008_0005, 32'h4);
        vecs[3]  = mk(0, 1, 1, 32'h2009_0003, 0, 0, 32'h0,        0, 32'h4,        0, 32'h2008_0005, 32'h4);
        vecs[4]  = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h8,        1, 32'h2009_0003, 32'h8);
        vecs[5]  = mk(0, 1, 1, 32'hAC09_0004, 1, 0, 32'h0,        0, 32'h8,        0, 32'h2009_0003, 32'h8);
        vecs[6]  = mk(0, 1, 0, 32'h0,         1, 0, 32'h0,        0, 32'h8,        0, 32'h2009_0003, 32'h8);
        vecs[7]  = mk(0, 1, 0, 32'h0,         1, 0, 32'h0,        0, 32'h8,        0, 32'h2009_0003, 32'h8);
        vecs[8]  = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,        0, 32'h8,        0, 32'h2009_0003, 32'h8);
        vecs[9]  = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'hC,        1, 32'hAC09_0004, 32'hC);
        vecs[10] = mk(0, 1, 0, 32'h0,         0, 1, 32'h40,       0, 32'hC,        0, 32'hAC09_0004, 32'hC);
        vecs[11] = mk(0, 1, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,        0, 32'h40,       0, 32'hAC09_0004, 32'hC);
        vecs[12] = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,        1, 32'h40,       0, 32'hAC09_0004, 32'hC);
        vecs[13] = mk(0, 1, 1, 32'h012A_4020, 0, 0, 32'h0,        0, 32'h40,       0, 32'hAC09_0004, 32'hC);
        vecs[14] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        1, 32'h44,       1, 32'h012A_4020, 32'h44);

        repeat (2) @(posedge clk);

        for (int i = 0; i < 15; i++) cycle($sformatf("vec%0d", i), vecs[i]);

        // Redirect on the accepting cycle while stalled: flush IF/ID, drop one response.
        cycle("rs1", mk(0, 1, 0, 32'h0,         0, 0, 32'h0,  1, 32'h44, 0, 32'h012A_4020, 32'h44));
        cycle("rs2", mk(0, 1, 1, 32'h8D28_0000, 0, 0, 32'h0,  0, 32'h44, 0, 32'h012A_4020, 32'h44));
        cycle("rs3", mk(0, 1, 0, 32'h0,         1, 1, 32'h80, 1, 32'h48, 1, 32'h8D28_0000, 32'h48));
        cycle("rs4", mk(0, 1, 0, 32'h0,         0, 0, 32'h0,  0, 32'h80, 0, 32'h8D28_0000, 32'h48));
        cycle("rs5", mk(0, 1, 1, 32'hBAD0_BAD0, 0, 0, 32'h0,  0, 32'h80, 0, 32'h8D28_0000, 32'h48));
        cycle("rs6", mk(0, 1, 0, 32'h0,         0, 0, 32'h0,  1, 32'h80, 0, 32'h8D28_0000, 32'h48));
        cycle("rs7", mk(0, 1, 1, 32'h2108_FFFF, 0, 0, 32'h0,  0, 32'h80, 0, 32'h8D28_0000, 32'h48));
        cycle("rs8", mk(0, 0, 0, 32'h0,         0, 0, 32'h0,  1, 32'h84, 1, 32'h2108_FFFF, 32'h84));

        // Backpressure at the top of the address space, then PC+4 wraps to zero.
        cycle("wr1", mk(0, 0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC, 1, 32'h84, 0, 32'h2108_FFFF, 32'h84));
        for (int i = 0; i < 4; i++)
            cycle($sformatf("wr_bp%0d", i),
                  mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h2108_FFFF, 32'h84));
        cycle("wr2", mk(0, 1, 0, 32'h0,         0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h2108_FFFF, 32'h84));
        cycle("wr3", mk(0, 1, 1, 32'h1000_FFFF, 0, 0, 32'h0, 0, 32'hFFFF_FFFC, 0, 32'h2108_FFFF, 32'h84));
        cycle("wr4", mk(0, 1, 0, 32'h0,         0, 0, 32'h0, 1, 32'h0,         1, 32'h1000_FFFF, 32'h0));

        // Reset while a held response is pending: it must never reach IF/ID.
        cycle("rh1", mk(0, 1, 1, 32'h0BAD_F00D, 1, 0, 32'h0, 0, 32'h0, 0, 32'h1000_FFFF, 32'h0));
        cycle("rh2", mk(0, 1, 0, 32'h0,         1, 0, 32'h0, 0, 32'h0, 0, 32'h1000_FFFF, 32'h0));
        cycle("rh3", mk(1, 1, 0, 32'h0,         1, 0, 32'h0, 0, 32'h0, 0, 32'h1000_FFFF, 32'h0));
        cycle("rh4", mk(0, 0, 0, 32'h0,         0, 0, 32'h0, 1, 32'h0, 0, 32'h0,         32'h0));
        cycle("rh5", mk(0, 1, 0, 32'h0,         0, 0, 32'h0, 1, 32'h0, 0, 32'h0,         32'h0));
        cycle("rh6", mk(0, 1, 1, 32'h2402_0001, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0,         32'h0));
        cycle("rh7", mk(0, 0, 0, 32'h0,         0, 0, 32'h0, 1, 32'h4, 1, 32'h2402_0001, 32'h4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
